mux12_rr_arbiter: RTL and testbench
===================================

// Module: mux12_rr_arbiter
// PURPOSE
// - Shares one 12-bit datapath between two requesters (A, B). Picks a winner by round-robin,
//   drives the select of the downstream 2:1 12-bit mux (sel), and registers the winning word.
// - One-entry output register with valid/ready handshake. Sits between the two operand/bus
//   sources and the single shared consumer.
// PARAMETERS
// - DW        12  datapath width (bits) of a_data, b_data, x_data
// - LOCK_MAX  4   max consecutive beats one locked requester may hold the grant (lock feature only)
// PORTS
// - clk      in   1   rising-edge clock
// - rst_n    in   1   synchronous reset, active-low
// - a_valid  in   1   requester A has a word
// - a_data   in   DW  requester A word
// - a_ready  out  1   A word accepted this cycle (a_valid & a_ready = transfer)
// - b_valid  in   1   requester B has a word
// - b_data   in   DW  requester B word
// - b_ready  out  1   B word accepted this cycle
// - x_valid  out  1   output register holds a word
// - x_data   out  DW  registered output word
// - x_src    out  1   source of x_data: 0 = A, 1 = B
// - x_ready  in   1   consumer takes x_data this cycle
// - sel      out  1   combinational mux select this cycle: 0 = A, 1 = B; holds last value when no grant
// - a_lock, b_lock  in 1  hold-grant requests (present only with MUX_ARB_LOCK_EN)
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): x_valid=0, x_data=0, x_src=0, last=1 (A wins first tie),
//   lock_cnt=0, sel=0. Output word in flight is dropped. a_ready/b_ready=0 while rst_n=0.
// - can_load = ~x_valid | x_ready.
// - Grant (combinational): only A valid -> A; only B valid -> B; both -> side != last; none -> no grant.
// - a_ready = can_load & grant_A; b_ready = can_load & grant_B. At most one ready high per cycle.
// - On transfer: x_data <= winner data, x_src <= winner, x_valid <= 1, last <= winner. Latency 1 clk.
// - x_valid clears when x_ready=1 and no new transfer the same cycle. Simultaneous drain and load
//   gives back-to-back throughput of 1 word/clk.
// - x_valid=1 & x_ready=0: x_data/x_src stable, both readies 0, last unchanged.
// - Requester valid/data must stay stable until ready. The arbiter does not check this.
// - FSM (2 states): EMPTY (x_valid=0) -> FULL on transfer. FULL -> EMPTY on x_ready & no transfer.
//   FULL -> FULL on x_ready & transfer, or on ~x_ready.
// CONFIGURATION
// - MUX_ARB_LOCK_EN defined:
//   - a_lock/b_lock ports exist. If the winner of the previous transfer (last) is valid with its
//     lock=1 and lock_cnt < LOCK_MAX, it wins even against the other requester.
//   - lock_cnt counts consecutive locked wins and saturates at LOCK_MAX. At LOCK_MAX the normal
//     round-robin decision applies.
//   - lock_cnt clears on a grant to the other side, or when the holder drops lock.
// - MUX_ARB_LOCK_EN undefined: no lock ports, no lock_cnt, pure round-robin.
// STRUCTURE
// - Shared package mux_arb_pkg: SRC_A=1'b0 / SRC_B=1'b1, the state encoding (ST_EMPTY, ST_FULL),
//   and the default DW.
// - One sub-module: rr_pick2. It is combinational. Inputs: valids, last, lock inputs.
//   Output: grant vector plus a has_grant flag.
// - Data select and output register stay in the top module.
// TESTING
// - Reset: hold rst_n=0 for 2 clks with a_valid=b_valid=1 -> a_ready=b_ready=0, x_valid=0.
//   First clk after release grants A.
// - Alternation: A and B valid continuously, a_data=12'h0A1, b_data=12'h0B2, x_ready=1 ->
//   x_data sequence 0A1, 0B2, 0A1, 0B2, one word per clk; x_src toggles.
// - Backpressure: x_ready=0 for 3 clks with x_valid=1 -> x_data held, a_ready=b_ready=0.
//   Then x_ready=1 -> next word loaded the same clk.
// - Single requester: only B valid with data 12'hFFF for 4 clks, x_ready=1 -> B granted each clk.
//   x_src=1 and x_data=FFF each clk; sel=1 each clk.
// - Mid-operation reset: x_valid=1, x_data=12'h123, rst_n=0 for one clk -> next cycle x_valid=0,
//   x_data=0. With both valid, the next grant goes to A.
// - Lock (MUX_ARB_LOCK_EN, LOCK_MAX=4): A valid+lock, B valid, x_ready=1 -> A wins 4 clks in a row,
//   then B. With the macro undefined, the same stimulus alternates A/B.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-requester round-robin 12-bit mux arbiter.
// Source encoding, output-register state encoding and default sizes.
package mux_arb_pkg;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam int DW_DEFAULT       = 12;
    localparam int LOCK_MAX_DEFAULT = 4;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick. hold forces a tie to go to the
// side that won last (used by the optional grant-lock feature).
module rr_pick2
    import mux_arb_pkg::*;
(
    input  logic       a_valid,
    input  logic       b_valid,
    input  logic       last,
    input  logic       hold,
    output logic [1:0] grant,
    output logic       has_grant
);

    logic pick;

    always_comb begin
        grant = 2'b00;
        pick  = SRC_A;
        unique case ({b_valid, a_valid})
            2'b01: pick = SRC_A;
            2'b10: pick = SRC_B;
            2'b11: pick = hold ? last : ~last;
            default: pick = SRC_A;
        endcase
        if (a_valid | b_valid) begin
            grant = (pick == SRC_B) ? 2'b10 : 2'b01;
        end
        has_grant = a_valid | b_valid;
    end

endmodule

// File: rtl/mux12_rr_arbiter.sv
// Round-robin arbiter sharing one DW-bit datapath between requesters A and B,
// with a one-entry registered output. Optional grant lock: MUX_ARB_LOCK_EN.
module mux12_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DW = DW_DEFAULT
`ifdef MUX_ARB_LOCK_EN
    ,
    parameter int LOCK_MAX = LOCK_MAX_DEFAULT
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef MUX_ARB_LOCK_EN
    input  logic          a_lock,
    input  logic          b_lock,
`endif
    input  logic          a_valid,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic          x_valid,
    output logic [DW-1:0] x_data,
    output logic          x_src,
    input  logic          x_ready,
    output logic          sel
);

    // Handshake: a word moves when valid & ready are both high on a rising
    // edge. Requesters hold valid/data until ready; the consumer sees x_valid
    // and takes the word by raising x_ready in that cycle.

    state_t        state_q, state_d;
    logic          last_q;
    logic          sel_q;
    logic          src_q;
    logic [DW-1:0] data_q;
    logic [1:0]    grant;
    logic          has_grant;
    logic          hold;
    logic          can_load;
    logic          xfer;

    rr_pick2 u_pick (
        .a_valid   (a_valid),
        .b_valid   (b_valid),
        .last      (last_q),
        .hold      (hold),
        .grant     (grant),
        .has_grant (has_grant)
    );

    assign can_load = (state_q == ST_EMPTY) | x_ready;
    assign a_ready  = rst_n & can_load & grant[0];
    assign b_ready  = rst_n & can_load & grant[1];
    assign xfer     = a_ready | b_ready;

    // sel follows the live grant and falls back to the previous grant when idle.
    assign sel     = (rst_n & has_grant) ? grant[1] : sel_q;
    assign x_valid = (state_q == ST_FULL);
    assign x_data  = data_q;
    assign x_src   = src_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (xfer) state_d = ST_FULL;
            ST_FULL:  if (x_ready && !xfer) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            src_q   <= SRC_A;
            last_q  <= SRC_B;
            sel_q   <= SRC_A;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                data_q <= b_ready ? b_data : a_data;
                src_q  <= b_ready ? SRC_B : SRC_A;
                last_q <= b_ready ? SRC_B : SRC_A;
            end
            if (has_grant) begin
                sel_q <= grant[1];
            end
        end
    end

`ifdef MUX_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);

    logic [CW-1:0] lock_cnt_q;
    logic          last_lock;
    logic          win_lock;

    assign last_lock = (last_q == SRC_B) ? b_lock : a_lock;
    assign win_lock  = b_ready ? b_lock : a_lock;
    assign hold      = last_lock & (lock_cnt_q < CW'(LOCK_MAX));

    // The first locked win of a run counts as 1, so the holder gets LOCK_MAX beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
        end else if (xfer) begin
            if (!win_lock) begin
                lock_cnt_q <= '0;
            end else if ((b_ready ? SRC_B : SRC_A) == last_q) begin
                if (lock_cnt_q != CW'(LOCK_MAX)) lock_cnt_q <= lock_cnt_q + 1'b1;
            end else begin
                lock_cnt_q <= CW'(1);
            end
        end else if (!last_lock) begin
            lock_cnt_q <= '0;
        end
    end
`else
    assign hold = 1'b0;
`endif

endmodule

// File: tb/tb_mux12_rr_arbiter.sv
// Directed and randomized checks of mux12_rr_arbiter against a cycle model
// built from the arbitration rules (round-robin, optional grant lock).
module tb_mux12_rr_arbiter;

`ifdef MUX_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif
    localparam int LMAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [11:0] a_data = '0, b_data = '0;
    logic        a_lock = 1'b0, b_lock = 1'b0;
    logic        a_ready, b_ready;
    logic        x_valid, x_src, x_ready = 1'b0, sel;
    logic [11:0] x_data;

    int tests = 0;
    int fails = 0;

    // reference state
    logic        m_xv = 1'b0, m_xs = 1'b0, m_last = 1'b1, m_sel = 1'b0;
    logic [11:0] m_xd = '0;
    int          m_cnt = 0;
    logic        e_ar = 1'b0, e_br = 1'b0;

    always #5 clk = ~clk;

    mux12_rr_arbiter dut (
        .clk     (clk),
`ifdef MUX_ARB_LOCK_EN
        .a_lock  (a_lock),
        .b_lock  (b_lock),
`endif
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .x_valid (x_valid),
        .x_data  (x_data),
        .x_src   (x_src),
        .x_ready (x_ready),
        .sel     (sel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle (from a falling edge), checks outputs, advances the model.
    task automatic step(input logic rst, input logic av, input logic [11:0] ad,
                        input logic bv, input logic [11:0] bd, input logic xr,
                        input logic al, input logic bl);
        logic lw, has, win, cl, wl;
        rst_n = rst; a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
        x_ready = xr; a_lock = al; b_lock = bl;
        #1;
        lw   = LOCK_ON && (m_last ? bl : al) && (m_cnt < LMAX);
        has  = av | bv;
        win  = (av && bv) ? (lw ? m_last : !m_last) : bv;
        cl   = !m_xv || xr;
        e_ar = rst && has && cl && !win;
        e_br = rst && has && cl && win;
        chk("a_ready", a_ready, e_ar);
        chk("b_ready", b_ready, e_br);
        chk("x_valid", x_valid, m_xv);
        chk("x_data", x_data, m_xd);
        chk("x_src", x_src, m_xs);
        if (rst) chk("sel", sel, has ? win : m_sel);
        if (!rst) begin
            m_xv = 1'b0; m_xd = '0; m_xs = 1'b0; m_last = 1'b1; m_sel = 1'b0; m_cnt = 0;
        end else begin
            if (e_ar || e_br) begin
                m_xv = 1'b1;
                m_xd = win ? bd : ad;
                m_xs = win;
                wl   = win ? bl : al;
                if (!wl) m_cnt = 0;
                else if (win == m_last) m_cnt = (m_cnt < LMAX) ? m_cnt + 1 : LMAX;
                else m_cnt = 1;
                m_last = win;
            end else begin
                if (xr) m_xv = 1'b0;
                if (!(m_last ? bl : al)) m_cnt = 0;
            end
            if (has) m_sel = win;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic        ra_v, rb_v, r_xr, r_al, r_bl, r_rst;
        logic [11:0] ra_d, rb_d;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset held with both requesters asking
        repeat (2) step(1'b0, 1'b1, 12'h0A1, 1'b1, 12'h0B2, 1'b1, 1'b0, 1'b0);

        // alternation, starting with A
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 12'h0A1, 1'b1, 12'h0B2, 1'b1, 1'b0, 1'b0);
            chk("alt_data", x_data, (i % 2) ? 12'h0B2 : 12'h0A1);
            chk("alt_src", x_src, (i % 2) ? 1'b1 : 1'b0);
        end

        // backpressure holds the word, then reload in the same cycle
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 12'h0A1, 1'b1, 12'h0B2, 1'b0, 1'b0, 1'b0);
            chk("bp_hold", x_data, 12'h0B2);
        end
        step(1'b1, 1'b1, 12'h0A1, 1'b1, 12'h0B2, 1'b1, 1'b0, 1'b0);
        chk("bp_reload", x_data, 12'h0A1);

        // single requester B
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 12'h000, 1'b1, 12'hFFF, 1'b1, 1'b0, 1'b0);
            chk("onlyb_data", x_data, 12'hFFF);
            chk("onlyb_src", x_src, 1'b1);
        end

        // reset in the middle of traffic
        step(1'b1, 1'b1, 12'h123, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        chk("mid_loaded", x_data, 12'h123);
        step(1'b0, 1'b1, 12'h0A1, 1'b1, 12'h0B2, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_valid", x_valid, 1'b0);
        chk("mid_rst_data", x_data, 12'h000);
        step(1'b1, 1'b1, 12'h0A1, 1'b1, 12'h0B2, 1'b1, 1'b0, 1'b0);
        chk("mid_rst_first_a", x_src, 1'b0);

        // A holds lock against a busy B
        step(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 12'h0A1, 1'b1, 12'h0B2, 1'b1, 1'b1, 1'b0);
            chk("lock_src", x_src, LOCK_ON ? ((i % 5) == 4) : ((i % 2) == 1));
        end

        // randomized traffic; a pending request keeps its valid/data
        ra_v = 1'b0; rb_v = 1'b0; ra_d = '0; rb_d = '0;
        for (int i = 0; i < 400; i++) begin
            if (!(ra_v && !e_ar)) begin
                ra_v = 1'($urandom_range(0, 1));
                ra_d = 12'($urandom);
            end
            if (!(rb_v && !e_br)) begin
                rb_v = 1'($urandom_range(0, 1));
                rb_d = 12'($urandom);
            end
            r_xr  = ($urandom_range(0, 3) != 0);
            r_al  = ($urandom_range(0, 3) != 0);
            r_bl  = ($urandom_range(0, 3) == 0);
            r_rst = ($urandom_range(0, 49) != 0);
            if (!r_rst) begin
                ra_v = 1'b0;
                rb_v = 1'b0;
            end
            step(r_rst, ra_v, ra_d, rb_v, rb_d, r_xr, r_al, r_bl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
